// File: rtl/trap_pkg.sv
// trap_pkg: exception bit indices, mcause codes, CSR addresses and FSM states for trap_handler
package trap_pkg;
  localparam int EXC_FETCH   = 0;
  localparam int EXC_DECODE  = 1;
  localparam int EXC_ANOMALY = 2;
  localparam int EXC_ECALL   = 3;
  localparam int EXC_EBREAK  = 4;
  localparam logic [3:0] CAUSE_FETCH   = 4'd1;
  localparam logic [3:0] CAUSE_DECODE  = 4'd2;
  localparam logic [3:0] CAUSE_ANOMALY = 4'd2;
  localparam logic [3:0] CAUSE_EBREAK  = 4'd3;
  localparam logic [3:0] CAUSE_ECALL   = 4'd11;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_TRAPCNT = 12'hB03;
  typedef enum logic [1:0] {IDLE, CAPTURE, REDIRECT, HALTED} trap_state_e;
endpackage

// File: rtl/trap_cause_encoder.sv
// trap_cause_encoder: priority-encodes the CPU exception bits into {valid, fatal, mcause code}
module trap_cause_encoder
  import trap_pkg::*;
(
  input  logic [4:0] exceptions,
  output logic       valid,
  output logic       fatal,
  output logic [3:0] cause
);
  assign valid = |exceptions;
  assign fatal = |exceptions[EXC_ANOMALY:EXC_FETCH];
  always_comb
    cause = exceptions[EXC_FETCH]   ? CAUSE_FETCH   :
            exceptions[EXC_DECODE]  ? CAUSE_DECODE  :
            exceptions[EXC_ANOMALY] ? CAUSE_ANOMALY :
            exceptions[EXC_EBREAK]  ? CAUSE_EBREAK  :
            exceptions[EXC_ECALL]   ? CAUSE_ECALL   : 4'd0;
endmodule

// File: rtl/trap_handler.sv
// trap_handler: machine-mode trap entry/mret sequencer with mepc/mcause/mtvec; TRAP_COUNT_EN adds a trap counter CSR
module trap_handler
  import trap_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter logic [DATA_WIDTH-1:0] MTVEC_RST = 64'h0000_0000_8000_0100
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [7:0]            exceptions_i,
  input  logic [DATA_WIDTH-1:0] pc_i,
  input  logic                  mret_i,
  input  logic                  csr_we_i,
  input  logic [11:0]           csr_addr_i,
  input  logic [DATA_WIDTH-1:0] csr_wdata_i,
  output logic [DATA_WIDTH-1:0] csr_rdata_o,
  output logic                  pc_hold_o,
  output logic                  redirect_o,
  output logic [DATA_WIDTH-1:0] redirect_pc_o,
  output logic                  halt_o
);
  trap_state_e state, state_d;
  logic [DATA_WIDTH-1:0] mepc, mcause, mtvec, target, cnt_rd;
  logic [3:0] cause, cause_q;
  logic exc_valid, exc_fatal, fatal_q, idle, trap, sw_we;
  logic unused_bits;
  trap_cause_encoder u_enc (
    .exceptions(exceptions_i[4:0]),
    .valid     (exc_valid),
    .fatal     (exc_fatal),
    .cause     (cause)
  );
  assign unused_bits = ^{exceptions_i[7:5], pc_i[1:0]};
  assign idle  = state == IDLE;
  assign trap  = idle && exc_valid;
  assign sw_we = idle && csr_we_i;
  always_comb
    state_d = state == IDLE     ? (exc_valid ? CAPTURE : mret_i ? REDIRECT : IDLE) :
              state == CAPTURE  ? (fatal_q ? HALTED : REDIRECT) :
              state == REDIRECT ? IDLE : HALTED;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      mepc    <= '0;
      mcause  <= '0;
      mtvec   <= MTVEC_RST;
      target  <= '0;
      cause_q <= '0;
      fatal_q <= 1'b0;
    end else begin
      state <= state_d;
      if (sw_we && csr_addr_i == CSR_MTVEC) mtvec <= {csr_wdata_i[DATA_WIDTH-1:2], 2'b00};
      // A capture in the same cycle as a software write keeps the captured PC
      if (trap) mepc <= {pc_i[DATA_WIDTH-1:2], 2'b00};
      else if (sw_we && csr_addr_i == CSR_MEPC) mepc <= {csr_wdata_i[DATA_WIDTH-1:2], 2'b00};
      if (state == CAPTURE) mcause <= DATA_WIDTH'(cause_q);
      else if (sw_we && csr_addr_i == CSR_MCAUSE) mcause <= csr_wdata_i;
      if (trap) begin
        cause_q <= cause;
        fatal_q <= exc_fatal;
      end
      if (idle && !exc_valid && mret_i) target <= mepc;
      else if (state == CAPTURE) target <= {mtvec[DATA_WIDTH-1:2], 2'b00};
    end
  end
`ifdef TRAP_COUNT_EN
  logic [63:0] trap_cnt;
  always_ff @(posedge clk_i) begin
    if (rst_i) trap_cnt <= '0;
    else if (trap) trap_cnt <= trap_cnt + {63'd0, ~&trap_cnt};
    else if (sw_we && csr_addr_i == CSR_TRAPCNT) trap_cnt <= 64'(csr_wdata_i);
  end
  assign cnt_rd = DATA_WIDTH'(trap_cnt);
`else
  assign cnt_rd = '0;
`endif
  assign csr_rdata_o = csr_addr_i == CSR_MTVEC   ? mtvec  :
                       csr_addr_i == CSR_MEPC    ? mepc   :
                       csr_addr_i == CSR_MCAUSE  ? mcause :
                       csr_addr_i == CSR_TRAPCNT ? cnt_rd : '0;
  assign pc_hold_o     = trap || !idle;
  assign redirect_o    = state == REDIRECT;
  assign redirect_pc_o = redirect_o ? target : '0;
  assign halt_o        = state == HALTED;
endmodule

// File: tb/tb_trap_handler.sv
// tb_trap_handler: directed + randomized checks of trap_handler against a cycle-queue reference model
module tb_trap_handler;
  localparam logic [63:0] MTVEC_RST = 64'h0000_0000_8000_0100;
`ifdef TRAP_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif
  logic clk = 1'b0, rst, mret, we, hold, redir, halt;
  logic [7:0] exc;
  logic [11:0] addr;
  logic [63:0] pc, wdata, rdata, rpc;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  trap_handler dut (
    .clk_i(clk), .rst_i(rst), .exceptions_i(exc), .pc_i(pc), .mret_i(mret),
    .csr_we_i(we), .csr_addr_i(addr), .csr_wdata_i(wdata), .csr_rdata_o(rdata),
    .pc_hold_o(hold), .redirect_o(redir), .redirect_pc_o(rpc), .halt_o(halt)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // One entry per future cycle of an in-flight sequence, plus the register effects at its closing edge
  typedef struct {
    bit hold, redir, halt, set_cause, go_halt;
    logic [63:0] pc, cause;
  } exp_t;
  exp_t q[$];
  logic [63:0] m_mepc, m_mcause, m_mtvec, m_cnt;
  bit m_halted;
  function automatic logic [63:0] m_read(input logic [11:0] a);
    return a == 12'h305 ? m_mtvec : a == 12'h341 ? m_mepc : a == 12'h342 ? m_mcause :
           (a == 12'hB03 && CNT_EN) ? m_cnt : 64'h0;
  endfunction
  function automatic logic [63:0] cause_of(input logic [7:0] e);
    if (e[0]) return 64'd1;
    if (e[1] || e[2]) return 64'd2;
    if (e[4]) return 64'd3;
    return 64'd11;
  endfunction
  task automatic model_cycle();
    exp_t e;
    bit free, fatal;
    logic [63:0] old_mepc, old_cnt;
    if (rst) begin
      q.delete();
      m_mepc = 0; m_mcause = 0; m_mtvec = MTVEC_RST; m_cnt = 0; m_halted = 0;
      return;
    end
    free = q.size() == 0 && !m_halted;
    if (q.size() != 0) e = q.pop_front();
    else e = '{hold: m_halted || exc[4:0] != 0, redir: 1'b0, halt: m_halted, set_cause: 1'b0,
               go_halt: 1'b0, pc: 64'h0, cause: 64'h0};
    check("pc_hold", hold, e.hold);
    check("redirect", redir, e.redir);
    check("redirect_pc", rpc, e.pc);
    check("halt", halt, e.halt);
    check("csr_rdata", rdata, m_read(addr));
    if (e.set_cause) m_mcause = e.cause;
    if (e.go_halt) m_halted = 1;
    if (!free) return;
    old_mepc = m_mepc;
    old_cnt = m_cnt;
    if (we) begin
      if (addr == 12'h305) m_mtvec = wdata & ~64'h3;
      if (addr == 12'h341) m_mepc = wdata & ~64'h3;
      if (addr == 12'h342) m_mcause = wdata;
      if (addr == 12'hB03 && CNT_EN) m_cnt = wdata;
    end
    if (exc[4:0] != 0) begin
      fatal = exc[2:0] != 0;
      m_mepc = pc & ~64'h3;
      if (CNT_EN) m_cnt = old_cnt == '1 ? old_cnt : old_cnt + 1;
      q.push_back('{hold: 1'b1, redir: 1'b0, halt: 1'b0, set_cause: 1'b1, go_halt: fatal,
                    pc: 64'h0, cause: cause_of(exc)});
      if (!fatal)
        q.push_back('{hold: 1'b1, redir: 1'b1, halt: 1'b0, set_cause: 1'b0, go_halt: 1'b0,
                      pc: m_mtvec, cause: 64'h0});
    end else if (mret)
      q.push_back('{hold: 1'b1, redir: 1'b1, halt: 1'b0, set_cause: 1'b0, go_halt: 1'b0,
                    pc: old_mepc, cause: 64'h0});
  endtask
  task automatic sample();
    @(negedge clk);
    model_cycle();
  endtask
  task automatic advance();
    @(posedge clk);
    #1;
  endtask
  task automatic idle_inputs();
    rst = 0; exc = 0; mret = 0; we = 0;
  endtask
  task automatic drive_rand();
    logic [11:0] addrs[5] = '{12'h305, 12'h341, 12'h342, 12'hB03, 12'h000};
    int r;
    r = $urandom_range(0, 99);
    rst = (m_halted && $urandom_range(0, 15) == 0) || $urandom_range(0, 299) == 0;
    exc = {3'($urandom_range(0, 7)), 5'b0};
    if (r < 10) exc[4:3] = 2'($urandom_range(1, 3));
    else if (r < 13) exc[4:0] = 5'($urandom_range(1, 31));
    mret = $urandom_range(0, 7) == 0;
    we = $urandom_range(0, 4) == 0;
    addr = addrs[$urandom_range(0, 4)];
    if (addr == 12'h000) addr = 12'($urandom);
    wdata = {32'($urandom), 32'($urandom)};
    if ($urandom_range(0, 3) == 0) wdata = 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 1));
    pc = {32'($urandom), 32'($urandom)};
  endtask
  initial begin
    rst = 1; exc = 0; pc = 0; mret = 0; we = 0; addr = 12'h305; wdata = 0;
    repeat (2) begin sample(); advance(); end
    idle_inputs();
    sample();
    check("rst_mtvec", rdata, 64'h8000_0100);
    check("rst_outputs", {hold, redir, halt}, 3'b000);
    advance();
    exc = 8'h08; pc = 64'h8000_0010; addr = 12'h341;
    sample(); check("ecall_hold_n", hold, 1); advance();
    exc = 0;
    sample(); check("ecall_mepc", rdata, 64'h8000_0010); check("ecall_hold_n1", hold, 1); advance();
    addr = 12'h342;
    sample(); check("ecall_redir", {redir, hold}, 2'b11); check("ecall_target", rpc, 64'h8000_0100);
    check("ecall_mcause", rdata, 64'd11); advance();
    mret = 1;
    sample(); check("mret_hold_m", hold, 0); advance();
    mret = 0;
    sample(); check("mret_redir", redir, 1); check("mret_target", rpc, 64'h8000_0010); advance();
    exc = 8'h18; mret = 1; pc = 64'h8000_0044;
    sample(); advance();
    idle_inputs();
    sample(); advance();
    sample(); check("ebreak_mcause", rdata, 64'd3); check("ebreak_target", rpc, 64'h8000_0100); advance();
    we = 1; addr = 12'h305; wdata = 64'h8000_0203;
    sample(); advance();
    we = 0;
    sample(); check("mtvec_wr", rdata, 64'h8000_0200); advance();
    exc = 8'h08; pc = 64'h8000_0058;
    sample(); advance();
    exc = 0;
    sample(); advance();
    we = 1; addr = 12'h341; wdata = 64'hDEAD_BEE0;
    sample(); check("ecall2_target", rpc, 64'h8000_0200); advance();
    we = 0;
    sample(); check("mepc_wr_dropped", rdata, 64'h8000_0058); advance();
    addr = 12'hB03;
    sample(); check("trap_count", rdata, CNT_EN ? 64'd3 : 64'd0); advance();
    exc = 8'h02;
    sample(); advance();
    exc = 0; addr = 12'h342;
    sample(); check("fatal_capture_halt", halt, 0); advance();
    sample(); check("fatal_mcause", rdata, 64'd2); advance();
    for (int i = 0; i < 20; i++) begin
      exc = 8'($urandom); mret = 1'($urandom);
      sample(); check("halt_sticky", {halt, redir, hold}, 3'b101); advance();
    end
    rst = 1; exc = 0; mret = 0;
    sample(); advance();
    rst = 0;
    sample(); check("halt_cleared", halt, 0); advance();
    for (int i = 0; i < 4000; i++) begin
      drive_rand();
      sample();
      advance();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
